// File: rtl/maxpool_stage.sv
// 2x2 signed max-pooling stage for a raster-ordered feature map.
// The horizontal max is formed on the fly; the vertical max uses a half-width line buffer.
module maxpool_stage #(
  parameter int DW   = 20,
  parameter int COLS = 64,
  parameter int ROWS = 64,
  parameter int AW   = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic signed [DW-1:0] out_data,
  output logic [AW-1:0]        out_addr,
  output logic                 done
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int HC = COLS / 2;
  localparam int HW = (HC > 1) ? $clog2(HC) : 1;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_POOL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                 state_r, state_nx_s;
  logic [CW-1:0]          c_r;
  logic [RW-1:0]          r_r;
  logic [AW-1:0]          oaddr_r;
  logic signed [DW-1:0]   hmax_r;
  logic signed [DW-1:0]   linebuf_r [HC];
  logic                   out_valid_r;
  logic signed [DW-1:0]   out_data_r;
  logic [AW-1:0]          out_addr_r;

  logic                   xfer_s;
  logic                   last_col_s;
  logic                   last_row_s;
  logic [HW-1:0]          lb_idx_s;
  logic signed [DW-1:0]   h_s;
  logic signed [DW-1:0]   lb_rd_s;

  function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a,
                                                input logic signed [DW-1:0] b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

  // Transfer qualification, horizontal max and line buffer read
  always_comb begin
    xfer_s     = in_valid && (state_r != ST_DONE);
    last_col_s = (c_r == CW'(COLS - 1));
    last_row_s = (r_r == RW'(ROWS - 1));
    lb_idx_s   = HW'(c_r >> 1);
    h_s        = smax(hmax_r, in_data);
    lb_rd_s    = linebuf_r[lb_idx_s];
  end

  // FSM next-state: row parity selects FILL/POOL, DONE lasts one cycle
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_FILL: begin
        if (xfer_s && last_col_s) begin
          state_nx_s = ST_POOL;
        end else begin
          state_nx_s = ST_FILL;
        end
      end
      ST_POOL: begin
        if (xfer_s && last_col_s) begin
          if (last_row_s) begin
            state_nx_s = ST_DONE;
          end else begin
            state_nx_s = ST_FILL;
          end
        end else begin
          state_nx_s = ST_POOL;
        end
      end
      ST_DONE: state_nx_s = ST_FILL;
      default: state_nx_s = ST_FILL;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_FILL;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Counters, horizontal hold register and registered pooled output
  always_ff @(posedge clk) begin
    if (reset) begin
      c_r         <= '0;
      r_r         <= '0;
      oaddr_r     <= '0;
      hmax_r      <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_addr_r  <= '0;
    end else begin
      out_valid_r <= 1'b0;
      if (state_r == ST_DONE) begin
        c_r     <= '0;
        r_r     <= '0;
        oaddr_r <= '0;
      end else if (xfer_s) begin
        if (last_col_s) begin
          c_r <= '0;
          if (last_row_s) begin
            r_r <= '0;
          end else begin
            r_r <= r_r + RW'(1);
          end
        end else begin
          c_r <= c_r + CW'(1);
        end
        // Outputs are produced in raster order, so a running index equals (r/2)*(COLS/2)+c/2
        if (!c_r[0]) begin
          hmax_r <= in_data;
        end else if (state_r == ST_POOL) begin
          out_valid_r <= 1'b1;
          out_data_r  <= smax(h_s, lb_rd_s);
          out_addr_r  <= oaddr_r;
          oaddr_r     <= oaddr_r + AW'(1);
        end else begin
          hmax_r <= hmax_r;
        end
      end else begin
        c_r <= c_r;
      end
    end
  end

  // Line buffer write; never cleared because each entry is rewritten before it is read
  always_ff @(posedge clk) begin
    if (!reset && xfer_s && (state_r == ST_FILL) && c_r[0]) begin
      linebuf_r[lb_idx_s] <= h_s;
    end else begin
      linebuf_r[lb_idx_s] <= linebuf_r[lb_idx_s];
    end
  end

  assign in_ready  = (state_r != ST_DONE);
  assign done      = (state_r == ST_DONE);
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_addr  = out_addr_r;

endmodule

// File: tb/tb_maxpool_stage.sv
// Scoreboard bench: a 4x4 instance for directed/random frames and a default 64x64 instance.
module tb_maxpool_stage;

  typedef struct {
    logic [9:0]          addr;
    logic signed [19:0]  data;
    logic                last;
    longint              cyc;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_s      [2];
  logic               in_valid_s [2];
  logic signed [19:0] in_data_s  [2];
  logic               in_ready_s [2];
  logic               out_valid_s[2];
  logic signed [19:0] out_data_s [2];
  logic [9:0]         out_addr_s [2];
  logic               done_s     [2];

  exp_t   q[2][$];
  longint cyc = 0;
  int     n_cmp = 0;
  int     n_bad = 0;
  int     done_cnt[2] = '{0, 0};
  int     frames_done[2] = '{0, 0};
  bit     expect_stall[2] = '{1'b0, 1'b0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  maxpool_stage #(.DW(20), .COLS(4), .ROWS(4), .AW(10)) dut_small (
    .clk(clk), .reset(rst_s[0]), .in_valid(in_valid_s[0]), .in_data(in_data_s[0]),
    .in_ready(in_ready_s[0]), .out_valid(out_valid_s[0]), .out_data(out_data_s[0]),
    .out_addr(out_addr_s[0]), .done(done_s[0]));

  maxpool_stage dut_big (
    .clk(clk), .reset(rst_s[1]), .in_valid(in_valid_s[1]), .in_data(in_data_s[1]),
    .in_ready(in_ready_s[1]), .out_valid(out_valid_s[1]), .out_data(out_data_s[1]),
    .out_addr(out_addr_s[1]), .done(done_s[1]));

  function automatic void chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic int dim(input int d);
    return (d == 0) ? 4 : 64;
  endfunction

  // Scoreboard monitors, one per instance
  for (genvar g = 0; g < 2; g++) begin : g_mon
    always @(negedge clk) begin
      exp_t e;
      if (done_s[g]) done_cnt[g]++;
      if (out_valid_s[g]) begin
        if (q[g].size() == 0) begin
          chk("unexpected_out_addr", out_addr_s[g], -1);
        end else begin
          e = q[g].pop_front();
          chk("out_addr", out_addr_s[g], e.addr);
          chk("out_data", out_data_s[g], e.data);
          chk("done_with_out", done_s[g], e.last);
          chk("latency_cycle", cyc, e.cyc);
        end
      end else begin
        chk("done_without_out", done_s[g], 0);
        if (q[g].size() > 0 && q[g][0].cyc < cyc) begin
          chk("missing_out_cycle", cyc, q[g][0].cyc);
          void'(q[g].pop_front());
        end
      end
    end
  end

  task automatic reset_check(input int d);
    @(negedge clk);
    chk("rst_out_valid", out_valid_s[d], 0);
    chk("rst_out_data", out_data_s[d], 0);
    chk("rst_out_addr", out_addr_s[d], 0);
    chk("rst_done", done_s[d], 0);
    chk("rst_in_ready", in_ready_s[d], 1);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int d, input int n);
    for (int k = 0; k < n; k++) begin
      in_valid_s[d] = 1'b0;
      in_data_s[d]  = 20'($urandom);
      @(negedge clk);
      if (k == 0 && expect_stall[d]) begin
        chk("done_cycle_in_ready", in_ready_s[d], 0);
        chk("done_cycle_done", done_s[d], 1);
      end
      @(posedge clk); #1;
    end
    expect_stall[d] = 1'b0;
  endtask

  // pmode: 0 raster index, 1 random, 2 all nines, 3 signed mix; gmode: 0 none, 1 toggle, 2 random
  task automatic run_frame(input int d, input int pmode, input int gmode, input int abort_at);
    int C = dim(d);
    int n = C * C;
    int stalls;
    int r, c, k;
    logic signed [19:0] pix[];
    logic signed [19:0] pooled[];
    logic signed [19:0] m;
    int mix[8] = '{-3, -1, -8, -2, -5, -4, -6, -7};
    pix = new[n];
    pooled = new[n / 4];
    for (int i = 0; i < n; i++) begin
      case (pmode)
        0: pix[i] = 20'(i);
        2: pix[i] = 20'sd9;
        3: pix[i] = (i < 8) ? 20'(mix[i]) : 20'($urandom);
        default: pix[i] = 20'($urandom);
      endcase
    end
    for (int p = 0; p < n / 4; p++) begin
      int pr = p / (C / 2);
      int pc = p % (C / 2);
      m = pix[2 * pr * C + 2 * pc];
      if (pix[2 * pr * C + 2 * pc + 1] > m) m = pix[2 * pr * C + 2 * pc + 1];
      if (pix[(2 * pr + 1) * C + 2 * pc] > m) m = pix[(2 * pr + 1) * C + 2 * pc];
      if (pix[(2 * pr + 1) * C + 2 * pc + 1] > m) m = pix[(2 * pr + 1) * C + 2 * pc + 1];
      pooled[p] = m;
    end
    for (int i = 0; i < n; i++) begin
      in_valid_s[d] = 1'b1;
      in_data_s[d]  = pix[i];
      if (i == abort_at) begin
        rst_s[d] = 1'b1;
        @(posedge clk); #1;
        rst_s[d] = 1'b0;
        in_valid_s[d] = 1'b0;
        expect_stall[d] = 1'b0;
        return;
      end
      stalls = 0;
      @(negedge clk);
      while (!in_ready_s[d] && stalls < 5) begin
        stalls++;
        @(negedge clk);
      end
      chk("stall_count", stalls, expect_stall[d] ? 1 : 0);
      expect_stall[d] = 1'b0;
      r = i / C;
      c = i % C;
      if ((r % 2 == 1) && (c % 2 == 1)) begin
        exp_t e;
        k = (r / 2) * (C / 2) + c / 2;
        e.addr = 10'(k);
        e.data = pooled[k];
        e.last = (i == n - 1);
        e.cyc  = cyc + 1;
        q[d].push_back(e);
      end
      @(posedge clk); #1;
      if (i != n - 1) begin
        k = (gmode == 1) ? 1 : (gmode == 2) ? int'($urandom_range(0, 3)) : 0;
        for (int j = 0; j < k; j++) begin
          in_valid_s[d] = 1'b0;
          in_data_s[d]  = 20'($urandom);
          @(posedge clk); #1;
        end
      end
    end
    in_valid_s[d] = 1'b0;
    expect_stall[d] = 1'b1;
    frames_done[d]++;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_s[d] = 1'b1;
      in_valid_s[d] = 1'b0;
      in_data_s[d] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst_s[0] = 1'b0;
    rst_s[1] = 1'b0;
    reset_check(0);
    reset_check(1);

    run_frame(0, 0, 0, -1);
    idle(0, 3);
    run_frame(0, 3, 0, -1);
    idle(0, 2);
    run_frame(0, 0, 1, -1);
    idle(0, 2);
    run_frame(0, 1, 0, 9);
    reset_check(0);
    run_frame(0, 2, 0, -1);
    idle(0, 2);
    for (int f = 0; f < 3; f++) run_frame(0, 1, 0, -1);
    idle(0, 2);
    for (int f = 0; f < 3; f++) begin
      run_frame(0, 1, 2, -1);
      idle(0, int'($urandom_range(1, 3)));
    end

    run_frame(1, 1, 0, -1);
    idle(1, 4);
    idle(0, 4);

    chk("queue_empty_small", q[0].size(), 0);
    chk("queue_empty_big", q[1].size(), 0);
    chk("done_count_small", done_cnt[0], frames_done[0]);
    chk("done_count_big", done_cnt[1], frames_done[1]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/maxpool_stage.md
MAXPOOL_STAGE -- requirements
Module: maxpool_stage

Interface
REQ-001 Parameters SHALL be (name, default, meaning): DW, 20, pixel width, signed, matching the conv-stage output word.
REQ-002 Parameter: COLS, 64, input feature-map width in pixels, even, >=2.
REQ-003 Parameter: ROWS, 64, input feature-map height in pixels, even, >=2.
REQ-004 Parameter: AW, 10, output address width, >= clog2(COLS*ROWS/4).
REQ-005 Port: clk, input, 1, single clock; all state updates on the rising edge.
REQ-006 Port: reset, input, 1; reset is synchronous and active-high.
REQ-007 Port: in_valid, input, 1, in_data carries a conv-stage (ReLU) result.
REQ-008 Port: in_data, input, DW, signed pixel in raster order (row-major, column 0 first).
REQ-009 Port: in_ready, output, 1, block accepts a pixel this cycle.
REQ-010 Port: out_valid, output, 1, one-cycle strobe: out_data/out_addr valid.
REQ-011 Port: out_data, output, DW, signed 2x2 maximum.
REQ-012 Port: out_addr, output, AW, pooled raster index = (r/2)*(COLS/2) + c/2.
REQ-013 Port: done, output, 1, one-cycle pulse at frame end.

Function
REQ-014 A pixel SHALL transfer only when in_valid && in_ready; in_valid gaps of any length are legal, and counters SHALL advance only on a transfer.
REQ-015 Column counter c SHALL cover 0..COLS-1 and row counter r SHALL cover 0..ROWS-1; c wraps to 0 and r increments on the transfer at c=COLS-1.
REQ-016 FSM states SHALL be FILL (r even), POOL (r odd) and DONE.
- FILL->POOL and POOL->FILL on the transfer at c=COLS-1.
- POOL->DONE instead when that transfer also has r=ROWS-1.
- DONE->FILL unconditionally after one cycle, with r=c=0.
REQ-017 in_ready SHALL be 1 in FILL and POOL and 0 in DONE; in_valid during DONE is ignored and not consumed.
REQ-018 Horizontal stage: on a transfer with c even, in_data SHALL be held in register hmax; on a transfer with c odd, h = signed max(hmax, in_data).
REQ-019 In FILL, h SHALL be written to line buffer entry c/2 (COLS/2 entries of DW bits).
REQ-020 In POOL, the block SHALL register out_data = signed max(h, linebuf[c/2]) and out_addr = (r/2)*(COLS/2) + c/2, and pulse out_valid for exactly one cycle.
REQ-021 Latency SHALL be one cycle: out_valid is high in the cycle after the odd-row, odd-column transfer.
REQ-022 Consecutive outputs SHALL be separated by >=1 idle cycle, which follows from REQ-018.
REQ-023 All comparisons SHALL be signed two's-complement, with no truncation or rounding; on a tie either operand is returned (equal value).
REQ-024 done SHALL be high for exactly the one cycle the FSM is in DONE, which coincides with out_valid for the final pooled pixel (addr COLS*ROWS/4-1).
REQ-025 Exactly COLS*ROWS/4 out_valid pulses SHALL occur per frame, with out_addr strictly increasing from 0.
REQ-026 The line buffer SHALL need no clear; every entry read in POOL is first written in the preceding FILL row.

Reset
REQ-027 With reset high at a clock edge, the block SHALL enter FILL with r=0, c=0, hmax=0, out_valid=0, out_data=0, out_addr=0, done=0, in_ready=1 (in the following cycle).
REQ-028 reset SHALL take priority over any simultaneous transfer, which is discarded.
REQ-029 Reset mid-frame SHALL abandon the partial frame with no further output for it; the next transfer is pixel (0,0) of a new frame.
REQ-030 Line buffer contents SHALL be left unreset.

Verification (COLS=4, ROWS=4 unless noted)
REQ-031 Back-to-back frame 0..15 (value = raster index) -> outputs (addr,data) = (0,5),(1,7),(2,13),(3,15); done coincides with (3,15); in_ready low one cycle after the last transfer.
REQ-032 Signed mix, row0 = -3,-1,-8,-2 and row1 = -5,-4,-6,-7 -> addr0 = -1, addr1 = -2.
REQ-033 in_valid toggling 1/0 on the same frame as REQ-031 -> identical output sequence, each out_valid exactly one cycle after its odd/odd transfer.
REQ-034 Reset asserted at pixel (2,1), then a full frame of all 9 -> no output before reset releases, then four outputs of 9, addr 0..3, one done.
REQ-035 in_valid held high across the DONE cycle -> that cycle is not consumed; the pixel presented then is taken as (0,0) of the next frame.
REQ-036 Defaults 64x64 random frame -> 1024 outputs matching a reference 2x2 max, addr 0..1023, a single done pulse.
